dlatch_deserializer: RTL and testbench

// - Downstream consumer of the NAND-gate D-latch output (q). Synchronises q into the clk domain.
// - Shifts in one bit per sample_en strobe and packs WIDTH bits MSB-first into a word.
// - Presents each word on a single-entry valid/ready output register.
// - Feeds latch-captured serial data to register-level logic.

---
 rtl/dlatch_deserializer.sv | 141 ++++++++++++++
 tb/tb_dlatch_deserializer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/dlatch_deserializer.sv
// dlatch_deserializer: synchronises latch q, packs WIDTH bits MSB-first.
// Optional q transition counter on edge_cnt: define DLATCH_EDGE_COUNT_EN.
module dlatch_deserializer #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             q_in,
  input  logic             sample_en,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic             overrun
`ifdef DLATCH_EDGE_COUNT_EN
  ,
  output logic [CNT_W-1:0] edge_cnt
`endif
);

  localparam int BW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [BW-1:0] LAST = BW'(WIDTH - 1);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  if (WIDTH < 2 || SYNC_STAGES < 2 || CNT_W < 1) begin : g_bad_params
    $error("dlatch_deserializer: illegal parameter value");
  end

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   q_s;
  logic [WIDTH-2:0]       shreg;
  logic [BW-1:0]          bit_cnt;
  logic                   word_done;
  logic [WIDTH-1:0]       word;
  state_t                 state;
  state_t                 state_nxt;
  logic                   load;
  logic                   drop;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], q_in};
    end
  end

  assign q_s       = sync_q[SYNC_STAGES-1];
  assign word      = {shreg, q_s};
  assign word_done = sample_en && (bit_cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (sample_en) begin
      shreg   <= word[WIDTH-2:0];
      bit_cnt <= word_done ? '0 : bit_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (1'b1)
      (state == EMPTY): begin
        if (word_done) state_nxt = FULL;
      end
      (state == FULL): begin
        if (out_ready && !word_done) state_nxt = EMPTY;
      end
      default: state_nxt = EMPTY;
    endcase
  end

  // A full register only takes a new word when the old one leaves.
  always_comb begin
    load = 1'b0;
    drop = 1'b0;
    unique case (1'b1)
      (state == EMPTY): begin
        load = word_done;
      end
      (state == FULL): begin
        load = word_done && out_ready;
        drop = word_done && !out_ready;
      end
      default: begin
        load = 1'b0;
        drop = 1'b0;
      end
    endcase
  end

  assign out_valid = (state == FULL);

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data <= '0;
    end else if (load) begin
      out_data <= word;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      overrun <= 1'b0;
    end else if (drop) begin
      overrun <= 1'b1;
    end
  end

`ifdef DLATCH_EDGE_COUNT_EN
  logic q_s_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      q_s_prev <= 1'b0;
      edge_cnt <= '0;
    end else begin
      q_s_prev <= q_s;
      if ((q_s != q_s_prev) && (edge_cnt != {CNT_W{1'b1}})) begin
        edge_cnt <= edge_cnt + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dlatch_deserializer.sv
// Bench for dlatch_deserializer: word table, directed corners,
// and random traffic against a queue-based reference model.
module tb_dlatch_deserializer;

  localparam int W  = 8;
  localparam int SS = 2;
  localparam int CW = 16;

  logic         clk;
  logic         rst;
  logic         q_in;
  logic         sample_en;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         overrun;
`ifdef DLATCH_EDGE_COUNT_EN
  logic [CW-1:0] edge_cnt;
`endif

  dlatch_deserializer #(
    .WIDTH(W),
    .SYNC_STAGES(SS),
    .CNT_W(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .q_in(q_in),
    .sample_en(sample_en),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_valid(out_valid),
    .overrun(overrun)
`ifdef DLATCH_EDGE_COUNT_EN
    ,
    .edge_cnt(edge_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_fail;

  // reference model state
  logic          hist[$];
  logic          bits[$];
  logic          m_valid;
  logic [W-1:0]  m_data;
  logic          m_ovr;
  logic [CW-1:0] m_cnt;
  logic          m_prev;

  typedef struct {
    logic [W-1:0] word;
    logic         rdy;
    logic [W-1:0] exp_data;
    logic         exp_valid;
    logic         exp_ovr;
  } vec_t;

  vec_t vt[5];

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
    end
  endtask

  task automatic model(input logic r, input logic q, input logic s,
                       input logic rd);
    logic         qs;
    logic         done;
    logic [W-1:0] w;
    if (r) begin
      hist.delete();
      for (int i = 0; i < SS; i++) hist.push_back(1'b0);
      bits.delete();
      m_valid = 1'b0;
      m_data  = '0;
      m_ovr   = 1'b0;
      m_cnt   = '0;
      m_prev  = 1'b0;
    end else begin
      qs = hist.pop_front();
      hist.push_back(q);
      done = 1'b0;
      w = '0;
      if (s) begin
        bits.push_back(qs);
        if (bits.size() == W) begin
          foreach (bits[i]) w = {w[W-2:0], bits[i]};
          bits.delete();
          done = 1'b1;
        end
      end
      if (done) begin
        if (!m_valid || rd) begin
          m_data  = w;
          m_valid = 1'b1;
        end else begin
          m_ovr = 1'b1;
        end
      end else if (m_valid && rd) begin
        m_valid = 1'b0;
      end
      if (qs != m_prev && m_cnt != {CW{1'b1}}) m_cnt = m_cnt + 1'b1;
      m_prev = qs;
    end
  endtask

  // called at a negedge; returns at the following negedge
  task automatic step(input logic r, input logic q, input logic s,
                      input logic rd);
    rst       = r;
    q_in      = q;
    sample_en = s;
    out_ready = rd;
    @(posedge clk);
    model(r, q, s, rd);
    #1;
    chk("model_valid", 32'(out_valid), 32'(m_valid));
    chk("model_data", 32'(out_data), 32'(m_data));
    chk("model_overrun", 32'(overrun), 32'(m_ovr));
`ifdef DLATCH_EDGE_COUNT_EN
    chk("model_edge_cnt", 32'(edge_cnt), 32'(m_cnt));
`endif
    @(negedge clk);
  endtask

  // q_in leads sample_en by the sync depth; out_ready only on the last strobe
  task automatic send_word(input logic [W-1:0] w, input logic rdy_last);
    for (int c = 0; c < W + SS; c++) begin
      step(1'b0, (c < W) ? w[W-1-c] : 1'b0, c >= SS,
           (c == W + SS - 1) ? rdy_last : 1'b0);
    end
  endtask

  task automatic chk_out(input string name, input logic v,
                         input logic [W-1:0] d, input logic o);
    chk({name, "_valid"}, 32'(out_valid), 32'(v));
    chk({name, "_data"}, 32'(out_data), 32'(d));
    chk({name, "_overrun"}, 32'(overrun), 32'(o));
  endtask

  initial begin
    logic r;
    logic q;
    logic s;
    logic rd;
`ifdef DLATCH_EDGE_COUNT_EN
    logic [CW-1:0] base;
    logic          tq;
`endif
    n_cmp  = 0;
    n_fail = 0;
    rst = 1'b1;
    q_in = 1'b1;
    sample_en = 1'b1;
    out_ready = 1'b1;
    model(1'b1, 1'b0, 1'b0, 1'b0);

    vt[0] = '{8'hA5, 1'b0, 8'hA5, 1'b1, 1'b0};
    vt[1] = '{8'h3C, 1'b1, 8'h3C, 1'b1, 1'b0};
    vt[2] = '{8'h11, 1'b1, 8'h11, 1'b1, 1'b0};
    vt[3] = '{8'h22, 1'b0, 8'h11, 1'b1, 1'b1};
    vt[4] = '{8'h5A, 1'b1, 8'h5A, 1'b1, 1'b1};

    @(negedge clk);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, 1'b1);
    chk_out("reset", 1'b0, 8'h00, 1'b0);
`ifdef DLATCH_EDGE_COUNT_EN
    chk("reset_edge_cnt", 32'(edge_cnt), 32'd0);
`endif

    for (int i = 0; i < 5; i++) begin
      send_word(vt[i].word, vt[i].rdy);
      chk_out($sformatf("vec%0d", i), vt[i].exp_valid, vt[i].exp_data,
              vt[i].exp_ovr);
    end

    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk_out("accept", 1'b0, 8'h5A, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk_out("idle_ready", 1'b0, 8'h5A, 1'b1);

    for (int c = 0; c < 5 + SS; c++) step(1'b0, 1'b1, c >= SS, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    chk_out("midword_rst", 1'b0, 8'h00, 1'b0);
    send_word(8'hF0, 1'b0);
    chk_out("after_rst", 1'b1, 8'hF0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk_out("drain", 1'b0, 8'hF0, 1'b0);

`ifdef DLATCH_EDGE_COUNT_EN
    for (int i = 0; i < SS + 1; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    base = m_cnt;
    tq = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tq = ~tq;
      step(1'b0, tq, 1'b0, 1'b0);
    end
    for (int i = 0; i < SS + 1; i++) step(1'b0, tq, 1'b0, 1'b0);
    chk("edge_cnt_10", 32'(edge_cnt), 32'(base + 16'd10));
    chk("edge_valid", 32'(out_valid), 32'd0);
`endif

    for (int n = 0; n < 3000; n++) begin
      r  = ($urandom_range(0, 299) == 0);
      q  = 1'($urandom);
      s  = ($urandom_range(0, 9) < 8);
      rd = ($urandom_range(0, 3) == 0);
      step(r, q, s, rd);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
